switch_func_eval: RTL and testbench
===================================

// Module: switch_func_eval
// PURPOSE
//  Parametrised board-level Boolean function evaluator for EGO1 switch labs.
//  NUM_VARS switch inputs are synchronised and debounced, then a truth-table
//  function is evaluated and registered, so the LED output is glitch-free.
//  The block counts accepted output transitions for the LED/7-seg display
//  logic. It sits between the switch pins and the LED/display drivers.
// PARAMETERS
//  NUM_VARS         4          number of switch variables, 1..6; sw bit0 = a, bit1 = b, ...
//  TRUTH_TABLE      16'hAEA2   2**NUM_VARS bits; f = TRUTH_TABLE[sw_stable]
//                              (default is f = ac + bc'd + ab'c')
//  DEBOUNCE_CYCLES  1_000_000  consecutive cycles a change must persist, >=1 (10 ms @ 100 MHz)
//  EVT_CNT_W        16         width of the transition counter
// PORTS
//  clk          in   1              system clock (100 MHz on EGO1)
//  rst_n        in   1              asynchronous active-low reset
//  sw_in        in   NUM_VARS       raw switch pins, asynchronous to clk
//  clear        in   1              synchronous clear of the counters
//  sw_stable    out  NUM_VARS       debounced switch vector
//  f_out        out  1              registered function output (drives LED)
//  f_change     out  1              1-cycle pulse in the cycle f_out changes
//  evt_count    out  EVT_CNT_W      saturating count of f_out transitions
//  hazard_count out  EVT_CNT_W      raw-path toggle count (only with HAZARD_MON_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): sync regs, debounce counters,
//    sw_stable, f_change and evt_count go to 0. f_out goes to TRUTH_TABLE[0],
//    so no f_change pulse is generated after reset.
//  - Synchroniser: 2 flops per channel, giving sw_sync.
//  - Debounce per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
//      sw_sync == sw_stable            -> cnt <= 0
//      differs, cnt <  DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//      differs, cnt == DEBOUNCE_CYCLES-1 -> sw_stable <= sw_sync, cnt <= 0
//    Any return to the stable value before the terminal count restarts the count.
//    A clean edge on sw_in reaches sw_stable after 2+DEBOUNCE_CYCLES clk edges.
//  - Evaluation: f_out <= TRUTH_TABLE[sw_stable], 1 cycle after sw_stable.
//    f_change <= (TRUTH_TABLE[sw_stable] != f_out).
//    Several channels committing in the same cycle produce one evaluation and
//    at most one f_change.
//  - evt_count: increments by 1 on each f_change and holds at 2**EVT_CNT_W-1.
//    clear forces it to 0; clear wins over a coincident f_change.
//  - Reset mid-debounce discards the partial count. After release the full
//    DEBOUNCE_CYCLES apply from zero.
//  - Fully synchronous to clk apart from reset; no combinational input-to-output path.
// CONFIGURATION
//  HAZARD_MON_EN defined:
//  - A raw path f_raw_q <= TRUTH_TABLE[sw_sync] is added.
//  - hazard_count increments (saturating) every cycle f_raw_q changes value.
//  - hazard_count is cleared by reset and by clear; clear wins over a coincident toggle.
//  - Used to show the students switch bounce that the debounced path rejects.
//  HAZARD_MON_EN undefined:
//  - The hazard_count port, f_raw_q and the raw-path logic are absent.
//  - All other behaviour is identical.
// TESTING  (bench uses DEBOUNCE_CYCLES=4 and default TRUTH_TABLE unless noted)
//  1 Reset: rst_n=0, sw_in=4'hF
//    -> sw_stable=0, f_out=0, f_change=0, evt_count=0; all hold until release.
//  2 Clean edge: sw_in 0000->0101, held
//    -> sw_stable=0101 at edge 6; f_out=1 at edge 7; single f_change pulse; evt_count=1.
//  3 Bounce: sw_in=0100 stable, then sw_in[0] toggles every 2 cycles for 20 cycles, ends at 0
//    -> sw_stable, f_out and evt_count unchanged.
//    -> With HAZARD_MON_EN: hazard_count=10.
//  4 Saturation: EVT_CNT_W=2, sw_in alternates 0000/0101 five times (each held 10 cycles)
//    -> evt_count 1,2,3,3,3.
//  5 clear asserted in the same cycle as f_change -> evt_count=0 next cycle.
//  6 rst_n pulsed low after 2 debounce counts on a pending change
//    -> outputs return to reset values immediately, no f_change after release,
//       and the change commits 2+4 edges after release.

Source files
------------

// File: rtl/switch_func_eval.sv
// Debounced switch-vector truth-table evaluator with a registered LED output and a saturating
// transition counter. Define HAZARD_MON_EN to add the raw-path toggle monitor (hazard_count).
module switch_func_eval #(
  parameter int unsigned                    NUM_VARS        = 4,
  parameter logic [(1 << NUM_VARS)-1:0]     TRUTH_TABLE     = 16'hAEA2,
  parameter int unsigned                    DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned                    EVT_CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_VARS-1:0]   sw_in,
  input  logic                  clear,
  output logic [NUM_VARS-1:0]   sw_stable,
  output logic                  f_out,
  output logic                  f_change,
  output logic [EVT_CNT_W-1:0]  evt_count
`ifdef HAZARD_MON_EN
  ,
  output logic [EVT_CNT_W-1:0]  hazard_count
`endif
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntTerm = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_VARS-1:0]            sync1_q, sync2_q;
  logic [NUM_VARS-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_VARS-1:0]            stable_q, stable_d;
  logic                           f_q, f_d;
  logic                           chg_q, chg_d;
  logic [EVT_CNT_W-1:0]           evt_q, evt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // A channel commits only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    for (int i = 0; i < int'(NUM_VARS); i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntTerm) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end

    f_d   = TRUTH_TABLE[stable_q];
    chg_d = (f_d != f_q);

    evt_d = evt_q;
    if (clear) begin
      evt_d = '0;
    end else if (chg_q && (evt_q != '1)) begin
      evt_d = evt_q + EVT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      f_q      <= TRUTH_TABLE[0];
      chg_q    <= 1'b0;
      evt_q    <= '0;
    end else begin
      sync1_q  <= sw_in;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      f_q      <= f_d;
      chg_q    <= chg_d;
      evt_q    <= evt_d;
    end
  end

  assign sw_stable = stable_q;
  assign f_out     = f_q;
  assign f_change  = chg_q;
  assign evt_count = evt_q;

`ifdef HAZARD_MON_EN
  // Undebounced evaluation, so switch bounce shows up as extra toggles.
  logic                 f_raw_q, f_raw_d;
  logic [EVT_CNT_W-1:0] haz_q, haz_d;

  always_comb begin
    f_raw_d = TRUTH_TABLE[sync2_q];
    haz_d   = haz_q;
    if (clear) begin
      haz_d = '0;
    end else if ((f_raw_d != f_raw_q) && (haz_q != '1)) begin
      haz_d = haz_q + EVT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_raw_q <= TRUTH_TABLE[0];
      haz_q   <= '0;
    end else begin
      f_raw_q <= f_raw_d;
      haz_q   <= haz_d;
    end
  end

  assign hazard_count = haz_q;
`endif

endmodule

// File: tb/tb_switch_func_eval.sv
// Directed bench for switch_func_eval: reset, clean edge, bounce rejection, clear priority,
// reset mid-debounce and counter saturation (second instance with a 2-bit counter).
module tb_switch_func_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  sw_in;
  logic [3:0]  sw_stable, sat_stable;
  logic        f_out, f_change, sat_f, sat_chg;
  logic [15:0] evt;
  logic [1:0]  sat_evt;
`ifdef HAZARD_MON_EN
  logic [15:0] haz;
  logic [1:0]  sat_haz;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_func_eval #(
    .NUM_VARS        (4),
    .TRUTH_TABLE     (16'hAEA2),
    .DEBOUNCE_CYCLES (4),
    .EVT_CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .clear     (clear),
    .sw_stable (sw_stable),
    .f_out     (f_out),
    .f_change  (f_change),
    .evt_count (evt)
`ifdef HAZARD_MON_EN
    ,
    .hazard_count (haz)
`endif
  );

  switch_func_eval #(
    .NUM_VARS        (4),
    .TRUTH_TABLE     (16'hAEA2),
    .DEBOUNCE_CYCLES (4),
    .EVT_CNT_W       (2)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .clear     (clear),
    .sw_stable (sat_stable),
    .f_out     (sat_f),
    .f_change  (sat_chg),
    .evt_count (sat_evt)
`ifdef HAZARD_MON_EN
    ,
    .hazard_count (sat_haz)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    sw_in = 4'hF;
    #2;
    check_eq("rst_stable", 32'(sw_stable), 32'h0);
    check_eq("rst_f", 32'(f_out), 32'h0);
    check_eq("rst_chg", 32'(f_change), 32'h0);
    check_eq("rst_evt", 32'(evt), 32'h0);
    tick(3);
    check_eq("rst_hold_stable", 32'(sw_stable), 32'h0);
    check_eq("rst_hold_f", 32'(f_out), 32'h0);
    check_eq("rst_hold_evt", 32'(evt), 32'h0);
    sw_in = 4'h0;
    rst_n = 1'b1;
    tick(10);
    check_eq("idle_chg", 32'(f_change), 32'h0);
    check_eq("idle_f", 32'(f_out), 32'h0);

    // Clean edge: commit at edge 6, f_out at edge 7, counter at edge 8.
    sw_in = 4'b0101;
    tick(5);
    check_eq("edge5_stable", 32'(sw_stable), 32'h0);
    tick(1);
    check_eq("edge6_stable", 32'(sw_stable), 32'h5);
    check_eq("edge6_f", 32'(f_out), 32'h0);
    tick(1);
    check_eq("edge7_f", 32'(f_out), 32'h1);
    check_eq("edge7_chg", 32'(f_change), 32'h1);
    tick(1);
    check_eq("edge8_chg", 32'(f_change), 32'h0);
    check_eq("edge8_evt", 32'(evt), 32'h1);

    // Bounce on bit0 around 0100 (f=0) must be rejected.
    sw_in = 4'b0100;
    tick(10);
    check_eq("pre_bnc_stable", 32'(sw_stable), 32'h4);
    check_eq("pre_bnc_f", 32'(f_out), 32'h0);
    check_eq("pre_bnc_evt", 32'(evt), 32'h2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_eq("clear_evt", 32'(evt), 32'h0);
`ifdef HAZARD_MON_EN
    check_eq("clear_haz", 32'(haz), 32'h0);
`endif
    for (int i = 0; i < 10; i++) begin
      sw_in[0] = ~sw_in[0];
      tick(2);
    end
    tick(10);
    check_eq("bnc_stable", 32'(sw_stable), 32'h4);
    check_eq("bnc_f", 32'(f_out), 32'h0);
    check_eq("bnc_evt", 32'(evt), 32'h0);
`ifdef HAZARD_MON_EN
    check_eq("bnc_haz", 32'(haz), 32'd10);
`endif

    // clear coincident with f_change wins.
    sw_in = 4'b0101;
    tick(7);
    check_eq("c_rise_chg", 32'(f_change), 32'h1);
    tick(3);
    check_eq("c_rise_evt", 32'(evt), 32'h1);
    sw_in = 4'b0100;
    tick(6);
    check_eq("c_fall_f_hold", 32'(f_out), 32'h1);
    tick(1);
    check_eq("c_fall_chg", 32'(f_change), 32'h1);
    check_eq("c_fall_f", 32'(f_out), 32'h0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_eq("c_win_evt", 32'(evt), 32'h0);
    tick(1);
    check_eq("c_win_evt2", 32'(evt), 32'h0);

    // Reset after two debounce counts on a pending change.
    sw_in = 4'b0101;
    tick(4);
    check_eq("pend_stable", 32'(sw_stable), 32'h4);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_stable", 32'(sw_stable), 32'h0);
    check_eq("mid_rst_f", 32'(f_out), 32'h0);
    check_eq("mid_rst_chg", 32'(f_change), 32'h0);
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check_eq("rel_chg", 32'(f_change), 32'h0);
    end
    check_eq("rel5_stable", 32'(sw_stable), 32'h0);
    tick(1);
    check_eq("rel6_stable", 32'(sw_stable), 32'h5);
    check_eq("rel6_chg", 32'(f_change), 32'h0);
    tick(1);
    check_eq("rel7_f", 32'(f_out), 32'h1);
    check_eq("rel7_chg", 32'(f_change), 32'h1);

    // Saturation on the 2-bit instance.
    rst_n = 1'b0;
    sw_in = 4'h0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int i = 1; i <= 5; i++) begin
      sw_in = (i % 2 == 1) ? 4'b0101 : 4'b0000;
      tick(10);
      check_eq("sat_evt", 32'(sat_evt), (i > 3) ? 32'd3 : 32'(i));
      check_eq("wide_evt", 32'(evt), 32'(i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
